// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The master drives operands and commands; the slave returns status and HI/LO.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             start;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             ready;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, op, start, mthi, mtlo,
    input  busy, ready, dz, hi, lo
  );

  modport slave (
    input  a, b, op, start, mthi, mtlo,
    output busy, ready, dz, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Sign-magnitude core: shift-add multiply, restoring divide, sign fix at the end.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           clrn,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_bz;
  logic               r_ready;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sgn;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remf;

  assign w_sgn   = ~bus.op[0];
  assign w_sa    = w_sgn & bus.a[WIDTH-1];
  assign w_sb    = w_sgn & bus.b[WIDTH-1];
  assign w_abs_a = w_sa ? -bus.a : bus.a;
  assign w_abs_b = w_sb ? -bus.b : bus.b;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_shl  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_opnd};

  // Divide-by-zero keeps the raw all-ones quotient.
  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = ((r_sa ^ r_sb) & ~r_bz)
                ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remf = r_sa ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bz    <= 1'b0;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_div  <= bus.op[1];
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_bz   <= bus.op[1] & (bus.b == '0);
            r_dz   <= 1'b0;
            r_acc  <= {{WIDTH{1'b0}},
                       bus.op[1] ? w_abs_a : w_abs_b};
            r_opnd <= bus.op[1] ? w_abs_b : w_abs_a;
          end else begin
            if (bus.mthi) r_hi <= bus.a;
            if (bus.mtlo) r_lo <= bus.a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_div) begin
            r_acc <= {(r_acc[0] ? w_sum
                       : {1'b0, r_acc[2*WIDTH-1:WIDTH]}),
                      r_acc[WIDTH-1:1]};
          end else if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shl[WIDTH-1:0];
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          r_ready <= 1'b1;
          r_dz    <= r_bz;
          if (r_div) begin
            r_hi <= w_remf;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.ready = r_ready;
  assign bus.dz    = r_dz;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic clrn = 1'b0;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo,
                                output logic dz);
    longint sp;
    logic [63:0] up;
    int sa;
    int sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {hi, lo} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      default: begin
        if (b == 0) begin
          lo = '1;
          hi = a;
          dz = 1'b1;
        end else if (op == 2'b11) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int busyc);
    @(negedge clk);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busyc = 0;
    while (!bus.ready && lat < 100) begin
      if (bus.busy) busyc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic edz;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int k;

    tv[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tv[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0};
    tv[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tv[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    tv[4] = '{2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1};
    tv[5] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0};
    tv[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0};
    tv[7] = '{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    tv[8] = '{2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0};
    tv[9] = '{2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0};

    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_dz", 64'(bus.dz), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, lat, bc);
      chk($sformatf("tv%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("tv%0d_busy", i), 64'(bc), 64'd33);
      chk($sformatf("tv%0d_hi", i), 64'(bus.hi), 64'(tv[i].hi));
      chk($sformatf("tv%0d_lo", i), 64'(bus.lo), 64'(tv[i].lo));
      chk($sformatf("tv%0d_dz", i), 64'(bus.dz), 64'(tv[i].dz));
    end

    // dz is sticky while idle and cleared by the next start
    run_op(2'b11, 32'd100, 32'd0, lat, bc);
    repeat (4) @(posedge clk);
    #1;
    chk("dz_sticky", 64'(bus.dz), 64'd1);
    @(negedge clk);
    bus.op = 2'b01;
    bus.a = 32'd3;
    bus.b = 32'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("dz_clear", 64'(bus.dz), 64'd0);
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("dz_next_lo", 64'(bus.lo), 64'd12);

    // start and mthi while busy are ignored
    @(negedge clk);
    bus.op = 2'b01;
    bus.a = 32'd5;
    bus.b = 32'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (!bus.ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 4) begin
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd9;
        bus.b = 32'd9;
      end
      if (k == 5) bus.start = 1'b0;
      if (k == 9) begin
        bus.mthi = 1'b1;
        bus.a = 32'hDEAD;
      end
      if (k == 10) bus.mthi = 1'b0;
    end
    chk("ign_lat", 64'(k), 64'd33);
    chk("ign_hilo", {bus.hi, bus.lo}, 64'd30);

    @(negedge clk);
    bus.a = 32'h1234;
    bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    chk("mtlo", {bus.hi, bus.lo}, 64'h1234);

    @(negedge clk);
    bus.a = 32'h55;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthilo", {bus.hi, bus.lo}, {32'h55, 32'h55});

    // start wins over a simultaneous mthi
    @(negedge clk);
    bus.op = 2'b01;
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.start = 1'b1;
    bus.mthi = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    chk("start_wins_hi", 64'(bus.hi), 64'h55);
    k = 0;
    while (!bus.ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("start_wins_res", {bus.hi, bus.lo}, 64'd6);

    // async reset mid-operation
    @(negedge clk);
    bus.a = 32'hABC;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    @(negedge clk);
    bus.op = 2'b11;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_ready", 64'(bus.ready), 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    run_op(2'b11, 32'd1000, 32'd7, lat, bc);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_hilo", {bus.hi, bus.lo}, {32'd6, 32'd142});

    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      model(rop, ra, rb, ehi, elo, edz);
      run_op(rop, ra, rb, lat, bc);
      chk($sformatf("rnd%0d_lat op=%0d", i, rop), 64'(lat), 64'd33);
      chk($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", i, rop, ra, rb),
          {bus.hi, bus.lo}, {ehi, elo});
      chk($sformatf("rnd%0d_dz", i), 64'(bus.dz), 64'(edz));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
